mdu_sequencer: RTL

//  Iterative multiply/divide sequencer for MULT/MULTU/DIV/DIVU; owns the HI/LO register pair.

---
 rtl/mdu_sequencer.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/mdu_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO pair.
// One shift-add or restoring-subtract step per cycle, then a sign-fix commit.
module mdu_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hilo_rd,
  input  logic             hilo_we,
  input  logic             hilo_sel,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int W2 = 2 * WIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_SIGN = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             a_neg_q, a_neg_d;
  logic             b_neg_q, b_neg_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [W2-1:0]    prod_q, prod_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic             sgn_op;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH:0]   mul_sum;
  logic [W2-1:0]    mul_nxt;
  logic [WIDTH:0]   div_r;
  logic [WIDTH+1:0] div_dif;
  logic [W2-1:0]    div_nxt;
  logic [W2-1:0]    mul_res;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

  always_comb begin
    sgn_op = ~op[0];
    mag_a  = (sgn_op && a[WIDTH-1]) ? -a : a;
    mag_b  = (sgn_op && b[WIDTH-1]) ? -b : b;
  end

  // Multiply: {acc, multiplier} shifts right, adding multiplicand on bit 0.
  always_comb begin
    mul_sum = {1'b0, prod_q[W2-1:WIDTH]} + {1'b0, opnd_q};
    if (prod_q[0]) begin
      mul_nxt = {mul_sum, prod_q[WIDTH-1:1]};
    end else begin
      mul_nxt = {1'b0, prod_q[W2-1:1]};
    end
  end

  // Divide: {rem, quo} shifts left, quotient bits enter at the bottom.
  always_comb begin
    div_r   = {prod_q[W2-1:WIDTH], prod_q[WIDTH-1]};
    div_dif = {1'b0, div_r} - {2'b00, opnd_q};
    if (div_dif[WIDTH+1]) begin
      div_nxt = {div_r[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
    end else begin
      div_nxt = {div_dif[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
    end
  end

  always_comb begin
    mul_res = (a_neg_q ^ b_neg_q) ? -prod_q : prod_q;
    quo     = prod_q[WIDTH-1:0];
    rem     = prod_q[W2-1:WIDTH];
    res_hi  = mul_res[W2-1:WIDTH];
    res_lo  = mul_res[WIDTH-1:0];
    if (op_q[1]) begin
      // remainder carries the dividend sign; on /0 it holds |a|, so hi = a
      res_hi = a_neg_q ? -rem : rem;
      if (dz_q) begin
        res_lo = '1;
      end else begin
        res_lo = (a_neg_q ^ b_neg_q) ? -quo : quo;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_neg_d = a_neg_q;
    b_neg_d = b_neg_q;
    dz_d    = dz_q;
    opnd_d  = opnd_q;
    prod_d  = prod_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (hilo_we) begin
          if (hilo_sel) begin
            hi_d = wdata;
          end else begin
            lo_d = wdata;
          end
        end
        if (start && !flush) begin
          state_d = S_CALC;
          cnt_d   = CNT_W'(WIDTH);
          op_d    = op;
          a_neg_d = sgn_op & a[WIDTH-1];
          b_neg_d = sgn_op & b[WIDTH-1];
          dz_d    = (b == '0);
          if (op[1]) begin
            prod_d = {{WIDTH{1'b0}}, mag_a};
            opnd_d = mag_b;
          end else begin
            prod_d = {{WIDTH{1'b0}}, mag_b};
            opnd_d = mag_a;
          end
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          prod_d = op_q[1] ? div_nxt : mul_nxt;
          cnt_d  = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = S_SIGN;
          end
        end
      end
      S_SIGN: begin
        state_d = S_IDLE;
        if (!flush) begin
          hi_d   = res_hi;
          lo_d   = res_lo;
          done_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      dz_q    <= 1'b0;
      opnd_q  <= '0;
      prod_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_neg_q <= a_neg_d;
      b_neg_q <= b_neg_d;
      dz_q    <= dz_d;
      opnd_q  <= opnd_d;
      prod_q  <= prod_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy  = (state_q == S_CALC) || (state_q == S_SIGN);
  assign stall = (hilo_rd | hilo_we) & busy;
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule
